alu_exec_unit: RTL and testbench

- Execution responder for the multi-cycle RV32I core. Consumes the ALUenable / ALU_instr_bus issue handshake from the control unit and returns ALUoutput / ALUready.
- Computes R/I/U/jump-link results in one cycle.
- Performs loads and stores through a req/ack data-memory port, including byte lanes, strobes and sign extension.

---
 rtl/rv_pkg.sv | 73 +++++++
 rtl/lsu_lane.sv | 50 +++++
 rtl/alu_exec_unit.sv | 207 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: decoded instruction-bus layout, group masks,
// execution-unit state encoding and base opcodes shared with the control unit.
package rv_pkg;

    localparam int unsigned XLEN_W  = 32;
    localparam int unsigned INSTR_W = 37;

    localparam int unsigned INSTR_ADD   = 0;
    localparam int unsigned INSTR_SUB   = 1;
    localparam int unsigned INSTR_SLL   = 2;
    localparam int unsigned INSTR_SLT   = 3;
    localparam int unsigned INSTR_SLTU  = 4;
    localparam int unsigned INSTR_XOR   = 5;
    localparam int unsigned INSTR_SRL   = 6;
    localparam int unsigned INSTR_SRA   = 7;
    localparam int unsigned INSTR_OR    = 8;
    localparam int unsigned INSTR_AND   = 9;
    localparam int unsigned INSTR_ADDI  = 10;
    localparam int unsigned INSTR_SLTI  = 11;
    localparam int unsigned INSTR_SLTIU = 12;
    localparam int unsigned INSTR_XORI  = 13;
    localparam int unsigned INSTR_ORI   = 14;
    localparam int unsigned INSTR_ANDI  = 15;
    localparam int unsigned INSTR_SLLI  = 16;
    localparam int unsigned INSTR_SRLI  = 17;
    localparam int unsigned INSTR_SRAI  = 18;
    localparam int unsigned INSTR_LB    = 19;
    localparam int unsigned INSTR_LH    = 20;
    localparam int unsigned INSTR_LW    = 21;
    localparam int unsigned INSTR_LBU   = 22;
    localparam int unsigned INSTR_LHU   = 23;
    localparam int unsigned INSTR_SB    = 24;
    localparam int unsigned INSTR_SH    = 25;
    localparam int unsigned INSTR_SW    = 26;
    localparam int unsigned INSTR_BEQ   = 27;
    localparam int unsigned INSTR_BNE   = 28;
    localparam int unsigned INSTR_BLT   = 29;
    localparam int unsigned INSTR_BGE   = 30;
    localparam int unsigned INSTR_BLTU  = 31;
    localparam int unsigned INSTR_BGEU  = 32;
    localparam int unsigned INSTR_JAL   = 33;
    localparam int unsigned INSTR_JALR  = 34;
    localparam int unsigned INSTR_LUI   = 35;
    localparam int unsigned INSTR_AUIPC = 36;

    localparam logic [INSTR_W-1:0] LOAD_MASK   = INSTR_W'(5'h1F) << INSTR_LB;
    localparam logic [INSTR_W-1:0] STORE_MASK  = INSTR_W'(3'h7)  << INSTR_SB;
    localparam logic [INSTR_W-1:0] BRANCH_MASK = INSTR_W'(6'h3F) << INSTR_BEQ;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_DONE     = 3'd4
    } exec_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // True when exactly one decoded-instruction bit is set.
    function automatic logic is_onehot(input logic [INSTR_W-1:0] v);
        return (v != '0) && ((v & (v - INSTR_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for the data-memory port: store strobes/replication
// and load lane select with sign or zero extension.
module lsu_lane (
    input  logic [4:0]  load_op,
    input  logic [2:0]  store_op,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb_c,
    output logic [31:0] wdata_c,
    output logic [31:0] load_data_c
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // load_op = {lhu, lbu, lw, lh, lb}; halfword lanes ignore ea_lo[0]
    always_comb begin
        rbyte       = 8'(rdata >> {ea_lo, 3'b000});
        rhalf       = ea_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data_c = '0;
        if (load_op[0]) begin
            load_data_c = {{24{rbyte[7]}}, rbyte};
        end else if (load_op[1]) begin
            load_data_c = {{16{rhalf[15]}}, rhalf};
        end else if (load_op[2]) begin
            load_data_c = rdata;
        end else if (load_op[3]) begin
            load_data_c = {24'd0, rbyte};
        end else if (load_op[4]) begin
            load_data_c = {16'd0, rhalf};
        end
    end

    // store_op = {sw, sh, sb}; data is replicated so every enabled lane is correct
    always_comb begin
        wstrb_c = '0;
        wdata_c = store_data;
        if (store_op[0]) begin
            wstrb_c = 4'b0001 << ea_lo;
            wdata_c = {4{store_data[7:0]}};
        end else if (store_op[1]) begin
            wstrb_c = ea_lo[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{store_data[15:0]}};
        end else if (store_op[2]) begin
            wstrb_c = 4'b1111;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execution responder: single-cycle ALU results plus loads/stores
// through a req/ack data-memory port with timeout.
module alu_exec_unit
    import rv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned XLEN        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ALUenable,
    input  logic [INSTR_W-1:0] ALU_instr_bus,
    input  logic [XLEN-1:0]    rs1_value,
    input  logic [XLEN-1:0]    rs2_value,
    input  logic [XLEN-1:0]    imm,
    input  logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    ALUoutput,
    output logic               ALUready,
    output logic               mem_err,
    output logic               mem_req,
    output logic               mem_we,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [3:0]         mem_wstrb,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic               mem_ack
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    exec_state_e        state_q, state_nxt;
    logic               en_q;
    logic [INSTR_W-1:0] bus_q, bus_nxt;
    logic [XLEN-1:0]    a_q, a_nxt, b_q, b_nxt, imm_q, imm_nxt, pc_q, pc_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;

    logic [XLEN-1:0]    out_nxt, addr_nxt, wdata_nxt;
    logic               rdy_nxt, err_nxt, req_nxt, we_nxt;
    logic [3:0]         wstrb_nxt;

    logic               accept_c, bus_valid_c, is_load_c, is_store_c;
    logic [XLEN-1:0]    ea_c, alu_res_c, lsu_wdata_c, lsu_load_c;
    logic [3:0]         lsu_wstrb_c;

    assign ea_c        = a_q + imm_q;
    assign bus_valid_c = is_onehot(bus_q);
    assign is_load_c   = bus_valid_c && (|(bus_q & LOAD_MASK));
    assign is_store_c  = bus_valid_c && (|(bus_q & STORE_MASK));
    assign accept_c    = ALUenable && !en_q;

    lsu_lane u_lsu_lane (
        .load_op     (bus_q[INSTR_LHU:INSTR_LB]),
        .store_op    (bus_q[INSTR_SW:INSTR_SB]),
        .ea_lo       (ea_c[1:0]),
        .store_data  (b_q),
        .rdata       (mem_rdata),
        .wstrb_c     (lsu_wstrb_c),
        .wdata_c     (lsu_wdata_c),
        .load_data_c (lsu_load_c)
    );

    // Non-memory result; malformed (zero or multi-hot) buses yield 0
    always_comb begin
        alu_res_c = '0;
        if (bus_valid_c) begin
            case (1'b1)
                bus_q[INSTR_ADD]:   alu_res_c = a_q + b_q;
                bus_q[INSTR_SUB]:   alu_res_c = a_q - b_q;
                bus_q[INSTR_SLL]:   alu_res_c = a_q << b_q[4:0];
                bus_q[INSTR_SLT]:   alu_res_c = XLEN'($signed(a_q) < $signed(b_q));
                bus_q[INSTR_SLTU]:  alu_res_c = XLEN'(a_q < b_q);
                bus_q[INSTR_XOR]:   alu_res_c = a_q ^ b_q;
                bus_q[INSTR_SRL]:   alu_res_c = a_q >> b_q[4:0];
                bus_q[INSTR_SRA]:   alu_res_c = $unsigned($signed(a_q) >>> b_q[4:0]);
                bus_q[INSTR_OR]:    alu_res_c = a_q | b_q;
                bus_q[INSTR_AND]:   alu_res_c = a_q & b_q;
                bus_q[INSTR_ADDI]:  alu_res_c = a_q + imm_q;
                bus_q[INSTR_SLTI]:  alu_res_c = XLEN'($signed(a_q) < $signed(imm_q));
                bus_q[INSTR_SLTIU]: alu_res_c = XLEN'(a_q < imm_q);
                bus_q[INSTR_XORI]:  alu_res_c = a_q ^ imm_q;
                bus_q[INSTR_ORI]:   alu_res_c = a_q | imm_q;
                bus_q[INSTR_ANDI]:  alu_res_c = a_q & imm_q;
                bus_q[INSTR_SLLI]:  alu_res_c = a_q << imm_q[4:0];
                bus_q[INSTR_SRLI]:  alu_res_c = a_q >> imm_q[4:0];
                bus_q[INSTR_SRAI]:  alu_res_c = $unsigned($signed(a_q) >>> imm_q[4:0]);
                bus_q[INSTR_JAL]:   alu_res_c = pc_q + XLEN'(4);
                bus_q[INSTR_JALR]:  alu_res_c = pc_q + XLEN'(4);
                bus_q[INSTR_LUI]:   alu_res_c = imm_q;
                bus_q[INSTR_AUIPC]: alu_res_c = pc_q + imm_q;
                |(bus_q & BRANCH_MASK): alu_res_c = '0;
                default:            alu_res_c = '0;
            endcase
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state_q;
        bus_nxt   = bus_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        imm_nxt   = imm_q;
        pc_nxt    = pc_q;
        cnt_nxt   = cnt_q;
        out_nxt   = ALUoutput;
        rdy_nxt   = ALUready;
        err_nxt   = mem_err;
        req_nxt   = mem_req;
        we_nxt    = mem_we;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        wstrb_nxt = mem_wstrb;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_c) begin
                    state_nxt = ST_EXEC;
                    bus_nxt   = ALU_instr_bus;
                    a_nxt     = rs1_value;
                    b_nxt     = rs2_value;
                    imm_nxt   = imm;
                    pc_nxt    = pc;
                    rdy_nxt   = 1'b0;
                end
            end
            ST_EXEC: begin
                if (is_load_c || is_store_c) begin
                    state_nxt = ST_MEM_REQ;
                    cnt_nxt   = '0;
                    req_nxt   = 1'b1;
                    we_nxt    = is_store_c;
                    addr_nxt  = {ea_c[XLEN-1:2], 2'b00};
                    wdata_nxt = lsu_wdata_c;
                    wstrb_nxt = lsu_wstrb_c;
                end else begin
                    state_nxt = ST_DONE;
                    out_nxt   = alu_res_c;
                    rdy_nxt   = 1'b1;
                end
            end
            ST_MEM_REQ: begin
                state_nxt = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    state_nxt = ST_DONE;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    wstrb_nxt = '0;
                    out_nxt   = lsu_load_c;
                    rdy_nxt   = 1'b1;
                    err_nxt   = 1'b0;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_nxt = ST_DONE;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    wstrb_nxt = '0;
                    out_nxt   = '0;
                    rdy_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            bus_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            ALUoutput <= '0;
            ALUready  <= 1'b0;
            mem_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state_q   <= state_nxt;
            en_q      <= ALUenable;
            bus_q     <= bus_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            imm_q     <= imm_nxt;
            pc_q      <= pc_nxt;
            cnt_q     <= cnt_nxt;
            ALUoutput <= out_nxt;
            ALUready  <= rdy_nxt;
            mem_err   <= err_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_wstrb <= wstrb_nxt;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued at issue
// and compared when ALUready rises.
module tb_alu_exec_unit;
    import rv_pkg::*;

    localparam int unsigned TO = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ALUenable;
    logic [INSTR_W-1:0] ALU_instr_bus;
    logic [31:0]        rs1_value, rs2_value, imm, pc;
    logic [31:0]        ALUoutput;
    logic               ALUready, mem_err, mem_req, mem_we;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;
    logic [3:0]         mem_wstrb;
    logic               mem_ack;

    alu_exec_unit #(.MEM_TIMEOUT(TO), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ALUenable     (ALUenable),
        .ALU_instr_bus (ALU_instr_bus),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .imm           (imm),
        .pc            (pc),
        .ALUoutput     (ALUoutput),
        .ALUready      (ALUready),
        .mem_err       (mem_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rdy_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [INSTR_W-1:0] oh(input int unsigned i);
        return INSTR_W'(1) << i;
    endfunction

    // Pop the scoreboard on each rising ALUready
    always @(negedge clk) begin
        if (ALUready && !rdy_prev) begin
            if (exp_q.size() == 0) check("sb_unexpected", 32'(exp_q.size()), 32'd1);
            else check(tag_q.pop_front(), ALUoutput, exp_q.pop_front());
        end
        rdy_prev = ALUready;
    end

    task automatic do_alu(input logic [INSTR_W-1:0] bus, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] i, input logic [31:0] p, input logic [31:0] exp,
                          input string tag, input int hold);
        @(negedge clk);
        ALU_instr_bus = bus; rs1_value = a; rs2_value = b; imm = i; pc = p;
        ALUenable = 1'b1;
        exp_q.push_back(exp); tag_q.push_back(tag);
        @(negedge clk);
        check({tag, "_rdy_clr"}, 32'(ALUready), 32'd0);
        @(negedge clk);
        check({tag, "_rdy_lat"}, 32'(ALUready), 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_rdy"}, 32'(ALUready), 32'd1);
            check({tag, "_hold_out"}, ALUoutput, exp);
        end
        ALUenable = 1'b0;
    endtask

    task automatic do_mem(input logic [INSTR_W-1:0] bus, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] i, input logic [31:0] rdata, input int ack_dly,
                          input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic [31:0] wmask,
                          input logic [31:0] e_out, input logic e_err, input string tag);
        int n;
        @(negedge clk);
        ALU_instr_bus = bus; rs1_value = a; rs2_value = b; imm = i; pc = 32'h0;
        mem_rdata = rdata;
        ALUenable = 1'b1;
        exp_q.push_back(e_out); tag_q.push_back(tag);
        @(negedge clk);
        check({tag, "_rdy_clr"}, 32'(ALUready), 32'd0);
        n = 0;
        while (!mem_req && n < 8) begin @(negedge clk); n++; end
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        check({tag, "_addr"}, mem_addr, e_addr);
        check({tag, "_we"}, 32'(mem_we), 32'(e_we));
        check({tag, "_strb"}, 32'(mem_wstrb), 32'(e_strb));
        check({tag, "_wdata"}, mem_wdata & wmask, e_wdata & wmask);
        if (ack_dly >= 0) begin
            repeat (ack_dly) @(negedge clk);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end else begin
            n = 0;
            do begin @(negedge clk); if (mem_req) n++; end while (mem_req && n < 40);
            check({tag, "_wait_cycles"}, 32'(n), 32'(TO));
        end
        n = 0;
        while (!ALUready && n < 40) begin @(negedge clk); n++; end
        check({tag, "_rdy"}, 32'(ALUready), 32'd1);
        check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        check({tag, "_err"}, 32'(mem_err), 32'(e_err));
        ALUenable = 1'b0;
    endtask

    initial begin
        int n;
        ALUenable = 1'b0; ALU_instr_bus = '0; rs1_value = '0; rs2_value = '0;
        imm = '0; pc = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", ALUoutput, 32'd0);
        check("rst_rdy", 32'(ALUready), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        rst_n = 1'b1;

        do_alu(oh(INSTR_ADD),   32'h7FFF_FFFF, 32'h1,         32'h0,   32'h0,   32'h8000_0000, "add", 3);
        do_alu(oh(INSTR_SRA),   32'h8000_0010, 32'h24,        32'h0,   32'h0,   32'hF800_0001, "sra", 0);
        do_alu(oh(INSTR_SLTU),  32'h1,         32'hFFFF_FFFF, 32'h0,   32'h0,   32'h1,         "sltu", 0);
        do_alu(oh(INSTR_SLT),   32'h1,         32'hFFFF_FFFF, 32'h0,   32'h0,   32'h0,         "slt", 0);
        do_alu(oh(INSTR_SUB),   32'h5,         32'h7,         32'h0,   32'h0,   32'hFFFF_FFFE, "sub", 0);
        do_alu(oh(INSTR_SLL),   32'h0000_0003, 32'h21,        32'h0,   32'h0,   32'h0000_0006, "sll", 0);
        do_alu(oh(INSTR_SRAI),  32'hF000_0000, 32'h0,         32'h404, 32'h0,   32'hFF00_0000, "srai", 0);
        do_alu(oh(INSTR_SRLI),  32'hF000_0000, 32'h0,         32'h4,   32'h0,   32'h0F00_0000, "srli", 0);
        do_alu(oh(INSTR_SLTI),  32'hFFFF_FFFF, 32'h0,         32'h0,   32'h0,   32'h1,         "slti", 0);
        do_alu(oh(INSTR_XORI),  32'h0000_FF00, 32'h0,         32'hFFFF_FFFF, 32'h0, 32'hFFFF_00FF, "xori", 0);
        do_alu(oh(INSTR_LUI),   32'h0,         32'h0,         32'h1234_5000, 32'h0, 32'h1234_5000, "lui", 0);
        do_alu(oh(INSTR_AUIPC), 32'h0,         32'h0,         32'h1000, 32'h100, 32'h0000_1100, "auipc", 0);
        do_alu(oh(INSTR_BEQ),   32'h5,         32'h5,         32'h10,  32'h200, 32'h0,         "beq", 0);
        do_alu('0,              32'h5,         32'h6,         32'h0,   32'h0,   32'h0,         "bus_zero", 0);
        do_alu(oh(INSTR_ADD) | oh(INSTR_OR), 32'h5, 32'h6,    32'h0,   32'h0,   32'h0,         "bus_multi", 0);

        do_mem(oh(INSTR_LB),  32'h1000, 32'h0, 32'h3, 32'h80AA_BBCC, 2,
               32'h1000, 1'b0, 4'b0000, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0, "lb");
        do_mem(oh(INSTR_LHU), 32'h1000, 32'h0, 32'h2, 32'h80AA_BBCC, 2,
               32'h1000, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0000_80AA, 1'b0, "lhu");
        do_mem(oh(INSTR_SH),  32'h2002, 32'h1234_ABCD, 32'h0, 32'h0, 1,
               32'h2000, 1'b1, 4'b1100, 32'hABCD_0000, 32'hFFFF_0000, 32'h0, 1'b0, "sh");
        do_mem(oh(INSTR_SB),  32'h3000, 32'h0000_0055, 32'h1, 32'h0, 3,
               32'h3000, 1'b1, 4'b0010, 32'h0000_5500, 32'h0000_FF00, 32'h0, 1'b0, "sb");
        do_mem(oh(INSTR_LW),  32'h4000, 32'h0, 32'h4, 32'h1111_2222, -1,
               32'h4004, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1, "lw_timeout");
        do_mem(oh(INSTR_LW),  32'h4000, 32'h0, 32'h8, 32'hCAFE_F00D, int'(TO),
               32'h4008, 1'b0, 4'b0000, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, "lw_ack_at_expiry");

        // Asynchronous reset while the access is outstanding
        @(negedge clk);
        ALU_instr_bus = oh(INSTR_LW); rs1_value = 32'h5000; imm = 32'h0; mem_rdata = 32'h0;
        ALUenable = 1'b1;
        n = 0;
        while (!mem_req && n < 8) begin @(negedge clk); n++; end
        check("rstw_req_pre", 32'(mem_req), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0; ALUenable = 1'b0;
        #1;
        check("rstw_req", 32'(mem_req), 32'd0);
        check("rstw_rdy", 32'(ALUready), 32'd0);
        check("rstw_out", ALUoutput, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rdata = 32'h0000_FFFF; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("late_ack_rdy", 32'(ALUready), 32'd0);
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_out", ALUoutput, 32'd0);

        do_alu(oh(INSTR_JAL), 32'h0, 32'h0, 32'h0, 32'h40, 32'h44, "jal", 1);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
